// File: rtl/uart_rx_deserializer.sv
// UART receiver: 16x oversampling, 2-of-3 majority per bit, 5-8 data bits with
// optional parity and 1/2 stop bits, one-deep valid/ready output slot.
module uart_rx_deserializer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             stop2,
  input  logic             rx,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t           state, state_next;
  logic             rx_s1, rx_s2, rx_prev;
  logic             fall;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] tick_cnt;
  logic             tick;
  logic [3:0]       sub_cnt;
  logic             samp7, samp8;
  logic             maj, mid, bit_end;
  logic [2:0]       bit_cnt;
  logic [1:0]       nbits_q;
  logic             par_en_q, par_odd_q, stop2_q;
  logic [7:0]       data_q;
  logic             perr_q, ferr_q;
  logic             complete;
  logic             slot_free;

  // Valid/ready: a character transfers on any clk where rx_valid && rx_ready;
  // rx_data and the error flags hold steady while rx_valid && !rx_ready.

  assign fall      = rx_prev & ~rx_s2;
  assign tick      = (state != IDLE) && (tick_cnt == div_q);
  assign maj       = (samp7 & samp8) | (samp7 & rx_s2) | (samp8 & rx_s2);
  assign mid       = tick && (sub_cnt == 4'd9);
  assign bit_end   = tick && (sub_cnt == 4'd15);
  assign slot_free = !rx_valid || rx_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Counters are held at zero in IDLE so bit phase aligns to the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      sub_cnt  <= '0;
      samp7    <= 1'b1;
      samp8    <= 1'b1;
    end else if (state == IDLE) begin
      tick_cnt <= '0;
      sub_cnt  <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        sub_cnt <= sub_cnt + 4'd1;
        if (sub_cnt == 4'd7) samp7 <= rx_s2;
        if (sub_cnt == 4'd8) samp8 <= rx_s2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    case (state)
      IDLE:   if (fall) state_next = START;
      START: begin
        if (mid && maj)   state_next = IDLE;
        else if (bit_end) state_next = DATA;
      end
      DATA:   if (bit_end && (bit_cnt == {1'b1, nbits_q}))
                state_next = par_en_q ? PARITY : STOP1;
      PARITY: if (bit_end) state_next = STOP1;
      STOP1: begin
        if (mid && !stop2_q) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (bit_end) begin
          state_next = STOP2;
        end
      end
      STOP2: begin
        if (mid) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      data_q    <= '0;
      bit_cnt   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (state == IDLE && fall) begin
        div_q     <= baud_div;
        nbits_q   <= data_bits;
        par_en_q  <= parity_en;
        par_odd_q <= parity_odd;
        stop2_q   <= stop2;
        data_q    <= '0;
        bit_cnt   <= '0;
        perr_q    <= 1'b0;
        ferr_q    <= 1'b0;
      end
      if (state == DATA && mid)     data_q[bit_cnt] <= maj;
      if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
      if (state == PARITY && mid)   perr_q <= (maj != ((^data_q) ^ par_odd_q));
      if ((state == STOP1 || state == STOP2) && mid && !maj) ferr_q <= 1'b1;
    end
  end

  // The final stop sample is folded in directly since ferr_q updates too late.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (complete && slot_free) begin
        rx_data    <= data_q;
        parity_err <= perr_q;
        frame_err  <= ferr_q | ~maj;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (complete && !slot_free)   overrun <= 1'b1;
      else if (rx_valid && rx_ready) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: serial frame driver, expected
// character queue built from the frame contents, and directed timing checks.
module tb_uart_rx_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic [1:0]  data_bits = 2'b11;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic        rx = 1'b1;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_err, frame_err, overrun, busy;
  logic [2:0]  state_dbg;

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  exp_q[$];
  logic        rand_ready = 1'b0;
  logic        hold_v = 1'b0;
  logic [9:0]  held, sb_w;

  uart_rx_deserializer #(.DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .data_bits(data_bits),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Builds the serial bit list for one character and the status it must produce.
  task automatic send_frame(input logic [7:0] data, input int d, input logic [1:0] db,
                            input logic pen, input logic podd, input logic st2,
                            input logic pflip, input logic stop_val,
                            input logic exp_it, input int rst_at);
    int nb, bit_clks, ones;
    logic [7:0] m, mask;
    logic pbit, perr;
    logic bits[$];
    nb       = int'(db) + 5;
    bit_clks = 16 * (d + 1);
    mask     = 8'((1 << nb) - 1);
    m        = data & mask;
    ones     = $countones(m);
    pbit     = 1'(ones % 2) ^ podd ^ pflip;
    perr     = pen && (1'((ones + int'(pbit)) % 2) != podd);
    baud_div = 16'(d); data_bits = db; parity_en = pen; parity_odd = podd; stop2 = st2;
    if (exp_it) exp_q.push_back({perr, ~stop_val, m});
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(m[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(stop_val);
    if (st2) bits.push_back(stop_val);
    for (int i = 0; i < bits.size(); i++) begin
      rx = bits[i];
      if (i == rst_at) begin
        wait_clks(bit_clks / 2);
        rst_n = 1'b0;
        #1;
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        exp_q.delete();
        rx = 1'b1;
        wait_clks(4);
        rst_n = 1'b1;
        return;
      end
      wait_clks(bit_clks);
    end
    rx = 1'b1;
  endtask

  // Compare process: transfers are checked against the queue, held slots for stability.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && rx_valid) check("hold", {parity_err, frame_err, rx_data}, held);
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char: got %0h want none", {parity_err, frame_err, rx_data});
        end else begin
          sb_w = exp_q.pop_front();
          check("char", {parity_err, frame_err, rx_data}, sb_w);
        end
      end
      hold_v = rx_valid && !rx_ready;
      held   = {parity_err, frame_err, rx_data};
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_flags", {parity_err, frame_err, overrun}, 0);
    check("reset_busy", busy, 0);
    check("reset_state", state_dbg, 0);
    rst_n = 1'b1;
    wait_clks(5);

    // Basic 8N1 at baud_div=3: 64 clk per bit, valid 619 clk after the pin edge.
    fork
      send_frame(8'hA5, 3, 2'b11, 0, 0, 0, 0, 1, 1, -1);
      begin
        repeat (2) @(negedge clk);
        check("busy_before_edge", busy, 0);
        @(negedge clk);
        check("busy_after_edge", busy, 1);
        repeat (615) @(negedge clk);
        check("basic_valid_early", rx_valid, 0);
        @(negedge clk);
        check("basic_valid", rx_valid, 1);
        check("basic_data", rx_data, 8'hA5);
        check("basic_errs", {parity_err, frame_err}, 0);
        @(negedge clk);
        check("basic_pulse", rx_valid, 0);
      end
    join
    wait_clks(10);

    send_frame(8'h35, 3, 2'b10, 1, 0, 0, 0, 1, 1, -1);
    wait_clks(10);
    send_frame(8'h35, 3, 2'b10, 1, 0, 0, 1, 1, 1, -1);
    wait_clks(10);
    send_frame(8'h1F, 3, 2'b00, 1, 1, 1, 0, 1, 1, -1);
    wait_clks(10);

    // Start-bit glitch of 5 ticks must be rejected.
    rx = 1'b0;
    wait_clks(5 * 4);
    rx = 1'b1;
    wait_clks(32 * 4);
    check("glitch_busy", busy, 0);
    check("glitch_valid", rx_valid, 0);
    send_frame(8'h3C, 3, 2'b11, 0, 0, 0, 0, 1, 1, -1);
    wait_clks(10);

    send_frame(8'h96, 3, 2'b11, 0, 0, 0, 0, 0, 1, -1);
    wait_clks(10);

    // Break: line low for 12 bit times.
    baud_div = 16'd3; data_bits = 2'b11; parity_en = 0; stop2 = 0;
    exp_q.push_back({1'b0, 1'b1, 8'h00});
    rx = 1'b0;
    wait_clks(12 * 64);
    rx = 1'b1;
    wait_clks(20);

    // Overrun: second character dropped while the first is held.
    rx_ready = 1'b0;
    send_frame(8'h11, 3, 2'b11, 0, 0, 0, 0, 1, 1, -1);
    wait_clks(10);
    send_frame(8'h22, 3, 2'b11, 0, 0, 0, 0, 1, 0, -1);
    wait_clks(10);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_flag", overrun, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check("ovr_clr_valid", rx_valid, 0);
    check("ovr_clr_flag", overrun, 0);

    // Completion in the same cycle as a handshake loads without overrun.
    send_frame(8'h33, 3, 2'b11, 0, 0, 0, 0, 1, 1, -1);
    wait_clks(10);
    fork
      send_frame(8'h44, 3, 2'b11, 0, 0, 0, 0, 1, 1, -1);
      begin
        repeat (618) @(negedge clk);
        check("same_old_data", rx_data, 8'h33);
        rx_ready = 1'b1;
        @(negedge clk);
        check("same_valid", rx_valid, 1);
        check("same_new_data", rx_data, 8'h44);
        check("same_overrun", overrun, 0);
      end
    join
    wait_clks(10);

    // Reset during DATA with a character already held in the slot.
    rx_ready = 1'b0;
    send_frame(8'hE7, 3, 2'b11, 0, 0, 0, 0, 1, 1, -1);
    wait_clks(10);
    send_frame(8'h5A, 3, 2'b11, 0, 0, 0, 0, 1, 0, 3);
    rx_ready = 1'b1;
    wait_clks(10);
    send_frame(8'hC3, 3, 2'b11, 0, 0, 0, 0, 1, 1, -1);
    wait_clks(10);

    // Randomized frames with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      send_frame(8'($urandom), int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0), 1, -1);
      wait_clks(int'($urandom_range(2, 10)));
    end
    rand_ready = 1'b0;
    rx_ready = 1'b1;
    wait_clks(50);
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Synthesizable UART receive stage sitting directly downstream of the master driver BFM's serial TX line. Oversamples the line 16x, validates start bits, and deserializes 5–8 data bits with optional parity and 1 or 2 stop bits. Presents each received character on a valid/ready port with per-character parity, framing and overrun status, for consumption by the slave-side monitor or scoreboard path.

## Interface
Parameters:
- DIV_W, 16, width of the oversample-tick divisor.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- baud_div  in  DIV_W  clk cycles per oversample tick, minus 1; 0 gives one tick per clk.
- data_bits  in  2  character length: 00=5, 01=6, 10=7, 11=8.
- parity_en  in  1  a parity bit follows the data bits.
- parity_odd  in  1  1 = odd parity, 0 = even.
- stop2  in  1  two stop bits are expected.
- rx  in  1  asynchronous serial input, idle high.
- rx_data  out  8  received character, right-aligned; unused upper bits are 0.
- rx_valid  out  1  rx_data and the status flags hold a character.
- rx_ready  in  1  consumer accepts the character.
- parity_err  out  1  parity mismatch for the presented character.
- frame_err  out  1  a stop bit was sampled low for the presented character.
- overrun  out  1  sticky; at least one character was dropped.
- busy  out  1  FSM is not in IDLE.

## Operation
- rx passes through a 2-flop synchronizer whose flops reset to 1. Falling-edge detect compares the synchronized value with a previous-value flop that also resets to 1.
- Tick counter counts 0..baud_div and emits tick when it equals baud_div. It is cleared in IDLE, so phase aligns to the detected edge.
- Sub-bit counter counts 0..15 ticks per bit. Each bit is sampled at ticks 7, 8 and 9 and resolved by 2-of-3 majority.
- Configuration inputs are latched at the falling edge. Changes during a frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: on a falling edge, latch config and go to START.
  - START: at tick 9, if the majority is 1 (glitch), return to IDLE with no output. Otherwise continue to tick 15, then go to DATA.
  - DATA: shift in LSB first. After data_bits+5 bits, go to PARITY if parity_en, else STOP1.
  - PARITY: compute the expected bit as XOR of the data bits, XOR parity_odd. A mismatch sets the internal perr.
  - STOP1: at tick 9, a sample of 0 sets the internal ferr. Then go to STOP2 if stop2; otherwise the frame completes and the FSM goes to IDLE immediately.
  - STOP2: same check as STOP1; the frame completes at its tick 9.
- On completion, if the output slot is free (rx_valid=0, or rx_valid&&rx_ready in the same cycle), load rx_data, parity_err and frame_err, and set rx_valid.
- If the slot is occupied and not being accepted, drop the character and set overrun.
- overrun clears on the next handshake (rx_valid&&rx_ready) in which no new drop occurs.
- rx_valid deasserts on handshake unless a new character loads in that same cycle.
- Break condition (line low through the stop bit) yields rx_data=0 and frame_err=1.

## Timing
- Reset values:
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE; all counters 0.
- Reset is asynchronous at any point, including mid-frame. It aborts the frame without output.
- If rx is low when reset releases, the first sampled low is treated as a falling edge and validated by START.
- Edge latency: synchronized rx lags pin rx by 2 clk. busy rises 1 clk after the synchronized falling edge.
- Completion latency: rx_valid rises 1 clk after the clk carrying the final stop-bit tick-9 sample.
- Frame length: 16*(baud_div+1) clk per bit. The next start edge is accepted immediately after completion, which tolerates up to half a bit of stop-bit shortening.
- The output port holds stable while rx_valid=1 and rx_ready=0.

## Test plan
- Basic receive: baud_div=3, 8N1, send 0xA5, rx_ready=1 → rx_valid pulses 1 clk with rx_data=0xA5, parity_err=0, frame_err=0; first bit lasts 64 clk.
- Short character with parity: 7E1, send 0x35 with a correct parity bit → rx_data=0x35, no errors. Repeat with the parity bit inverted → parity_err=1. Repeat as 5O2 with 0x1F → rx_data=0x1F, no errors.
- Start-bit glitch: rx low for 5 ticks, then high → no rx_valid, busy returns to 0, and a following 0x3C is received correctly.
- Framing error and break: 8N1 with the stop bit driven 0 → frame_err=1. Line held low for 12 bit times → rx_data=0x00, frame_err=1.
- Overrun: rx_ready=0, send 0x11 then 0x22 → rx_data stays 0x11 and overrun=1. Assert rx_ready for 1 clk → rx_valid=0 and overrun=0. Also complete a frame in the same cycle as a handshake → new character loads with no overrun.
- Reset mid-frame: assert rst_n=0 during DATA of 0x5A → all outputs return to reset values immediately. After release, 0xC3 is received correctly.
